// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: Wishbone master that drives the OpenCores I2C core
// through complete single-register write and read transactions.
//
// Request handshake: a request transfers on the rising edge where
// req_valid && req_ready. req_ready is high only while the sequencer is
// IDLE. The request fields are latched at that edge, so the host may change
// them afterwards. The response is a single-cycle rsp_valid pulse that
// carries rsp_err and rsp_rdata. There is no backpressure on the response.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [19:0] TIMEOUT  = 20'd500000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic       m_ack_i,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE, LOAD_TXR, WR_CR, POLL_SR,
    CHECK, STOP_CR, STOP_POLL, READ_RXR, RESP
  } state_t;

  state_t      state;
  logic        rnw;
  logic [6:0]  dev;
  logic [7:0]  regad;
  logic [7:0]  wdata;
  logic [1:0]  phase;
  logic [1:0]  err;
  logic        sr_rxack;
  logic        sr_al;
  logic [19:0] tmo_cnt;
  logic [7:0]  txr_val;
  logic [7:0]  cr_val;
  logic        tmo_hit;
  logic        last_rd;

  assign dbg_state = state;
  assign tmo_hit   = (tmo_cnt == TIMEOUT);
  // Read phase 3 receives a byte, so RxACK there is our own NACK, not a slave reply.
  assign last_rd   = rnw && (phase == 2'd3);

  // Transmit byte and command for the current byte phase
  always_comb begin
    txr_val = 8'h00;
    cr_val  = 8'h00;
    case (phase)
      2'd0: begin txr_val = {dev, 1'b0}; cr_val = 8'h90; end
      2'd1: begin txr_val = regad;       cr_val = 8'h10; end
      2'd2: begin
        if (rnw) begin txr_val = {dev, 1'b1}; cr_val = 8'h90; end
        else     begin txr_val = wdata;       cr_val = 8'h50; end
      end
      default: begin txr_val = 8'h00; cr_val = 8'h68; end
    endcase
  end

  // Sequencer FSM. Each access state raises stb and drops it on the ack
  // edge. This leaves an idle bus cycle before the next access.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= INIT_PRL;
      req_ready <= 1'b0;
      busy_o    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 2'b00;
      m_adr_o   <= 3'd0;
      m_dat_o   <= 8'h00;
      m_we_o    <= 1'b0;
      m_stb_o   <= 1'b0;
      rnw       <= 1'b0;
      dev       <= 7'd0;
      regad     <= 8'h00;
      wdata     <= 8'h00;
      phase     <= 2'd0;
      err       <= 2'b00;
      sr_rxack  <= 1'b0;
      sr_al     <= 1'b0;
      tmo_cnt   <= 20'd0;
    end else begin
      case (state)
        INIT_PRL: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd0; m_dat_o <= PRESCALE[7:0]; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0; state <= INIT_PRH;
          end
        end
        INIT_PRH: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd1; m_dat_o <= PRESCALE[15:8]; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0; state <= INIT_CTR;
          end
        end
        INIT_CTR: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd2; m_dat_o <= 8'h80; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o   <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy_o    <= 1'b0;
          end
        end
        IDLE: begin
          if (req_valid) begin
            rnw       <= req_rnw;
            dev       <= req_dev;
            regad     <= req_reg;
            wdata     <= req_wdata;
            phase     <= 2'd0;
            err       <= 2'b00;
            req_ready <= 1'b0;
            busy_o    <= 1'b1;
            state     <= LOAD_TXR;
          end
        end
        LOAD_TXR: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd3; m_dat_o <= txr_val; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0; state <= WR_CR;
          end
        end
        WR_CR: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd4; m_dat_o <= cr_val; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0; tmo_cnt <= 20'd0; state <= POLL_SR;
          end
        end
        POLL_SR: begin
          if (!tmo_hit) tmo_cnt <= tmo_cnt + 20'd1;
          if (!m_stb_o) begin
            if (tmo_hit) begin
              err   <= 2'b11;
              state <= STOP_CR;
            end else begin
              m_adr_o <= 3'd4; m_we_o <= 1'b0; m_stb_o <= 1'b1;
            end
          end else if (m_ack_i) begin
            m_stb_o  <= 1'b0;
            sr_rxack <= m_dat_i[7];
            sr_al    <= m_dat_i[5];
            if (!m_dat_i[1]) state <= CHECK;
          end
        end
        CHECK: begin
          if (sr_al) begin
            // Arbitration lost: the core has already released the bus, so no STOP.
            err       <= 2'b10;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b10;
            rsp_rdata <= 8'h00;
          end else if (sr_rxack && !last_rd) begin
            err   <= 2'b01;
            state <= STOP_CR;
          end else if (last_rd) begin
            state <= READ_RXR;
          end else if (!rnw && (phase == 2'd2)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= 8'h00;
          end else if (rnw && (phase == 2'd2)) begin
            // The receive phase has no byte to transmit, so go straight to CR.
            phase <= 2'd3;
            state <= WR_CR;
          end else begin
            phase <= phase + 2'd1;
            state <= LOAD_TXR;
          end
        end
        STOP_CR: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd4; m_dat_o <= 8'h40; m_we_o <= 1'b1; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0; tmo_cnt <= 20'd0; state <= STOP_POLL;
          end
        end
        STOP_POLL: begin
          if (!tmo_hit) tmo_cnt <= tmo_cnt + 20'd1;
          if (!m_stb_o) begin
            if (tmo_hit) begin
              // Keep the error that sent us here; a stuck stop does not overwrite it.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= 8'h00;
            end else begin
              m_adr_o <= 3'd4; m_we_o <= 1'b0; m_stb_o <= 1'b1;
            end
          end else if (m_ack_i) begin
            m_stb_o <= 1'b0;
            if (!m_dat_i[6]) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= 8'h00;
            end
          end
        end
        READ_RXR: begin
          if (!m_stb_o) begin
            m_adr_o <= 3'd3; m_we_o <= 1'b0; m_stb_o <= 1'b1;
          end else if (m_ack_i) begin
            m_stb_o   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= m_dat_i;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 2'b00;
          rsp_rdata <= 8'h00;
          busy_o    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT_PRL;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: bench for i2c_reg_sequencer. A behavioural model of
// the I2C core register file answers Wishbone accesses. Expected write traces
// and responses are derived from a per-byte transaction table.
module tb_i2c_reg_sequencer;

  localparam logic [19:0] TMO = 20'd1000;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy_o;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i = 8'h00;
  logic       m_we_o;
  logic       m_stb_o;
  logic       m_ack_i = 1'b0;
  logic [3:0] dbg_state;

  i2c_reg_sequencer #(.PRESCALE(16'd99), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy_o(busy_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          rsp_cnt = 0;

  // ---------------- core model state ----------------
  int         cr_idx, nack_idx, al_idx, stuck_idx, wait_cnt, poll_left;
  logic [7:0] rd_byte;
  logic       tip, busy, al, rxack, sto_pend, stop_wait, stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic slave_clear();
    cr_idx = 0; wait_cnt = 0; poll_left = 0;
    tip = 0; busy = 0; al = 0; rxack = 0; sto_pend = 0; stop_wait = 0; stuck = 0;
    obs_q.delete();
  endtask

  // One register access of the modelled I2C core
  task automatic slave_access();
    if (m_we_o) begin
      obs_q.push_back({m_adr_o, m_dat_o});
      if (m_adr_o == 3'd4) begin
        if (m_dat_o[5] || m_dat_o[4]) begin
          tip = 1; poll_left = $urandom_range(0, 3);
          stuck = (cr_idx == stuck_idx);
          rxack = (cr_idx == nack_idx);
          al = (cr_idx == al_idx);
          if (m_dat_o[7]) busy = 1;
          sto_pend = m_dat_o[6];
          cr_idx++;
        end else if (m_dat_o[6]) begin
          stop_wait = 1; poll_left = $urandom_range(0, 3);
        end
      end
      m_dat_i = 8'h00;
    end else if (m_adr_o == 3'd4) begin
      if (tip && !stuck) begin
        if (poll_left == 0) begin
          tip = 0;
          if (al || sto_pend) busy = 0;
        end else poll_left--;
      end else if (stop_wait && !stuck) begin
        if (poll_left == 0) begin busy = 0; stop_wait = 0; end
        else poll_left--;
      end
      m_dat_i = {rxack, busy, al, 3'b000, tip, 1'b0};
    end else if (m_adr_o == 3'd3) begin
      m_dat_i = rd_byte;
    end else begin
      m_dat_i = 8'h00;
    end
  endtask

  // Core Wishbone slave with 0..2 wait cycles; ack lasts one cycle
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
      check("stb_drop_after_ack", 32'(m_stb_o), 32'd0);
    end else if (m_stb_o) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        slave_access();
        m_ack_i = 1'b1;
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  // Counts response pulses
  always @(negedge wb_clk_i) if (rsp_valid === 1'b1) rsp_cnt++;

  // Reference: a transaction is a list of bytes, each a TXR load (except
  // the receive byte) and a CR command. The first failure ends the list.
  task automatic build_expect(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [7:0] wd, input int nk, input int ai, input int st,
                              input logic [7:0] rb, output logic [1:0] e_err, output logic [7:0] e_rd);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int nbytes;
    nbytes = rnw ? 4 : 3;
    txr[0] = {dev, 1'b0}; txr[1] = rg; txr[2] = rnw ? {dev, 1'b1} : wd; txr[3] = 8'h00;
    if (rnw) begin cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = 8'h90; cr[3] = 8'h68; end
    else     begin cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = 8'h50; cr[3] = 8'h00; end
    e_err = 2'b00; e_rd = 8'h00;
    exp_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      if (i < 3) exp_q.push_back({3'd3, txr[i]});
      exp_q.push_back({3'd4, cr[i]});
      if (st == i) begin exp_q.push_back({3'd4, 8'h40}); e_err = 2'b11; return; end
      if (ai == i) begin e_err = 2'b10; return; end
      if (nk == i && !(rnw && i == 3)) begin exp_q.push_back({3'd4, 8'h40}); e_err = 2'b01; return; end
    end
    if (rnw) e_rd = rb;
  endtask

  task automatic compare_writes(input string name);
    check({name, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_wr%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_init(input string name);
    int cyc;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    exp_q.delete();
    exp_q.push_back({3'd0, 8'h63});
    exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd2, 8'h80});
    compare_writes(name);
  endtask

  task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int nk, input int ai, input int st,
                         input logic [7:0] rb, input string name);
    logic [1:0] e_err;
    logic [7:0] e_rd;
    int cyc;
    bit got;
    slave_clear();
    nack_idx = nk; al_idx = ai; stuck_idx = st; rd_byte = rb;
    build_expect(rnw, dev, rg, wd, nk, ai, st, rb, e_err, e_rd);
    rsp_cnt = 0;
    req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    check({name, "_busy_acc"}, 32'(busy_o), 32'd1);
    check({name, "_ready_acc"}, 32'(req_ready), 32'd0);
    // Keep valid high with different fields: must be neither accepted nor used
    req_rnw = ~rnw; req_dev = 7'($urandom_range(0, 127));
    req_reg = 8'($urandom_range(0, 255)); req_wdata = 8'($urandom_range(0, 255));
    got = 0; cyc = 0;
    while (!got && cyc < 6000) begin
      if (rsp_valid === 1'b1) got = 1;
      else begin tick(); cyc++; end
    end
    check({name, "_rsp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_err"}, 32'(rsp_err), 32'(e_err));
      check({name, "_rdata"}, 32'(rsp_rdata), 32'(e_rd));
      check({name, "_busy_rsp"}, 32'(busy_o), 32'd1);
    end
    req_valid = 1'b0;
    tick();
    check({name, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
    check({name, "_busy_after"}, 32'(busy_o), 32'd0);
    check({name, "_rsp_cnt"}, 32'(rsp_cnt), 32'd1);
    compare_writes(name);
  endtask

  initial begin
    int cyc;
    logic       r_rnw;
    logic [6:0] r_dev;
    logic [7:0] r_reg, r_wd, r_rb;
    int nb, nk, ai, st;

    // Reset state
    slave_clear();
    nack_idx = 9; al_idx = 9; stuck_idx = 9; rd_byte = 8'h00;
    tick(); tick(); tick();
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_stb", 32'(m_stb_o), 32'd0);
    check("rst_we", 32'(m_we_o), 32'd0);
    check("rst_adr", 32'(m_adr_o), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    wb_rst_i = 1'b0;
    check_init("init");

    // Directed transactions
    run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 9, 9, 9, 8'h00, "wr_basic");
    run_txn(1'b1, 7'h50, 8'h34, 8'h00, 9, 9, 9, 8'h5C, "rd_basic");
    run_txn(1'b0, 7'h7F, 8'h01, 8'h02, 0, 9, 9, 8'h00, "addr_nack");
    run_txn(1'b0, 7'h50, 8'h12, 8'h33, 9, 9, 1, 8'h00, "tip_stuck");
    run_txn(1'b0, 7'h51, 8'h20, 8'h44, 9, 9, 9, 8'h00, "after_tmo");
    run_txn(1'b1, 7'h22, 8'h10, 8'h00, 9, 2, 9, 8'h00, "arb_lost");
    run_txn(1'b1, 7'h50, 8'h40, 8'h00, 3, 9, 9, 8'hC3, "rd_nack_last");
    run_txn(1'b1, 7'h50, 8'h41, 8'h00, 2, 9, 9, 8'h11, "rd_restart_nack");

    // Reset during the second byte's status polling
    slave_clear();
    nack_idx = 9; al_idx = 9; stuck_idx = 1; rd_byte = 8'h00;
    rsp_cnt = 0;
    req_valid = 1'b1; req_rnw = 1'b0; req_dev = 7'h50; req_reg = 8'h12; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!(cr_idx == 2 && m_stb_o === 1'b1 && m_we_o === 1'b0) && cyc < 300) begin tick(); cyc++; end
    check("midrst_reached_poll", 32'(cr_idx), 32'd2);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_stb", 32'(m_stb_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd1);
    check("midrst_ready", 32'(req_ready), 32'd0);
    tick(); tick(); tick();
    slave_clear();
    wb_rst_i = 1'b0;
    check_init("reinit");
    check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);

    // Randomised transactions
    for (int t = 0; t < 16; t++) begin
      r_rnw = 1'($urandom_range(0, 1));
      r_dev = 7'($urandom_range(0, 127));
      r_reg = 8'($urandom_range(0, 255));
      r_wd  = 8'($urandom_range(0, 255));
      r_rb  = 8'($urandom_range(0, 255));
      nb = r_rnw ? 4 : 3;
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : 9;
      ai = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : 9;
      st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : 9;
      run_txn(r_rnw, r_dev, r_reg, r_wd, nk, ai, st, r_rb, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
